// File: rtl/vec_data_mem.sv
// vec_data_mem: lane-serial vector load/store responder over a single-port word array.
// Define VEC_DATA_MEM_ADDR_FAULT_EN to reject requests that run past the top of storage.
module vec_data_mem #(
    parameter int registerSize = 8,
    parameter int vectorSize   = 4,
    parameter int addrWidth    = 16,
    parameter int memDepth     = 256
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       req,
    input  logic                                       we,
    input  logic                                       vec,
    input  logic [addrWidth-1:0]                       addr,
    input  logic [vectorSize-1:0][registerSize-1:0]    wdata,
    output logic [vectorSize-1:0][registerSize-1:0]    rdata,
    output logic                                       ack,
    output logic                                       busy,
    output logic                                       fault
);
    localparam int AW = $clog2(memDepth);
    localparam int LW = vectorSize > 1 ? $clog2(vectorSize) : 1;
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;

    logic [1:0] state;
    logic we_r, vec_r;
    logic [AW-1:0] base, idx;
    logic [LW-1:0] lane;
    logic last;
    logic [vectorSize-1:0][registerSize-1:0] wdata_r;
    logic [registerSize-1:0] mem [memDepth];

    assign idx  = base + AW'(lane);
    assign last = lane == LW'(vec_r ? vectorSize - 1 : 0);
    assign ack  = state == DONE;
    assign busy = state != IDLE;

`ifdef VEC_DATA_MEM_ADDR_FAULT_EN
    logic fault_r, over;
    logic [addrWidth:0] end_addr;
    // End address is computed one bit wider so a request straddling the top cannot wrap
    assign end_addr = {1'b0, addr} + (addrWidth + 1)'(vec ? vectorSize - 1 : 0);
    assign over     = end_addr >= (addrWidth + 1)'(memDepth);
    assign fault    = ack & fault_r;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rdata <= '0;
            lane  <= '0;
`ifdef VEC_DATA_MEM_ADDR_FAULT_EN
            fault_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req) begin
                    we_r    <= we;
                    vec_r   <= vec;
                    base    <= addr[AW-1:0];
                    wdata_r <= wdata;
                    lane    <= '0;
                    rdata   <= '0;
`ifdef VEC_DATA_MEM_ADDR_FAULT_EN
                    fault_r <= over;
                    state   <= over ? DONE : ACCESS;
`else
                    state   <= ACCESS;
`endif
                end
                ACCESS: begin
                    if (!we_r) rdata[lane] <= mem[idx];
                    lane <= lane + 1'b1;
                    if (last) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
`ifdef VEC_DATA_MEM_ADDR_FAULT_EN
                    fault_r <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never cleared; reset only suppresses the in-flight lane write
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && we_r) mem[idx] <= wdata_r[lane];
    end
endmodule
